// File: rtl/pe_ws_dbuf_pkg.sv
// Shared helpers for the weight-stationary PE and the array edge adders:
// saturation bounds and an overflow-aware add result for any ACC_WIDTH up to ACC_MAX_W-1.
package pe_ws_dbuf_pkg;

    localparam int ACC_MAX_W = 128;

    typedef logic [ACC_MAX_W-1:0] acc_max_t;

    typedef struct packed {
        acc_max_t result;
        logic     ovf;
    } sat_res_t;

    // Bounds are returned sign-extended to ACC_MAX_W; callers keep the low w bits.
    function automatic acc_max_t acc_max(input int unsigned w);
        return (acc_max_t'(1) << (w - 1)) - acc_max_t'(1);
    endfunction

    function automatic acc_max_t acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

    // sum_ext holds a (w+1)-bit sum sign-extended to ACC_MAX_W+1 bits.
    function automatic sat_res_t sat_add(input logic [ACC_MAX_W:0] sum_ext,
                                         input int unsigned w, input logic sat_en);
        sat_res_t r;
        r.ovf    = sum_ext[w] ^ sum_ext[w-1];
        r.result = sum_ext[ACC_MAX_W-1:0];
        if (r.ovf && sat_en)
            r.result = sum_ext[w] ? acc_min(w) : acc_max(w);
        return r;
    endfunction

endpackage

// File: rtl/pe_ws_dbuf_mac_ws_sat.sv
// Multiply-accumulate slice of the PE: optional product register with matching
// acc_i delay, then a saturating (or wrapping) add into the registered partial sum.
module mac_ws_sat
    import pe_ws_dbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int MUL_PIPE   = 0,
    parameter int SAT_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] weight_i,
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  acc_valid_o,
    output logic                  ovf_evt_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    logic [PW-1:0]        s_prod;
    logic [ACC_WIDTH-1:0] s_acc;
    logic                 s_vld;
    logic [ACC_WIDTH:0]   sum;
    sat_res_t             res;
    logic                 unused_hi;

    assign prod = $signed(data_i) * $signed(weight_i);

    generate
        if (MUL_PIPE != 0) begin : g_pipe
            logic [PW-1:0]        prod_q;
            logic [ACC_WIDTH-1:0] acc_q;
            logic                 vld_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    prod_q <= '0;
                    acc_q  <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= valid_i;
                    if (valid_i) begin
                        prod_q <= prod;
                        acc_q  <= acc_i;
                    end
                end
            end

            assign s_prod = prod_q;
            assign s_acc  = acc_q;
            assign s_vld  = vld_q;
        end else begin : g_comb
            assign s_prod = prod;
            assign s_acc  = acc_i;
            assign s_vld  = valid_i;
        end
    endgenerate

    // One guard bit above ACC_WIDTH: overflow shows as the top two bits disagreeing.
    assign sum = {s_acc[ACC_WIDTH-1], s_acc} + {{(ACC_WIDTH + 1 - PW){s_prod[PW-1]}}, s_prod};
    assign res = sat_add({{(ACC_MAX_W - ACC_WIDTH){sum[ACC_WIDTH]}}, sum},
                         ACC_WIDTH, (SAT_EN != 0));
    assign unused_hi = ^res.result[ACC_MAX_W-1:ACC_WIDTH];
    assign ovf_evt_o = s_vld & res.ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_o       <= '0;
            acc_valid_o <= 1'b0;
        end else begin
            acc_valid_o <= s_vld;
            if (s_vld)
                acc_o <= res.result[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE: shadow weight shifts down the column while the
// active weight feeds the MAC; swap copies shadow to active and ripples right.
module pe_ws_dbuf
    import pe_ws_dbuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 64,
    parameter int MUL_PIPE   = 0,
    parameter int SAT_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  acc_valid_o,
    input  logic                  wshift_i,
    input  logic [DATA_WIDTH-1:0] weight_i,
    output logic [DATA_WIDTH-1:0] weight_o,
    input  logic                  swap_i,
    output logic                  swap_o,
    output logic                  ovf_o,
    input  logic                  ovf_clr_i
);

    generate
        if (ACC_WIDTH < 2 * DATA_WIDTH + 1 || ACC_WIDTH >= ACC_MAX_W) begin : g_bad_acc_width
            $error("pe_ws_dbuf: ACC_WIDTH must be in [2*DATA_WIDTH+1, ACC_MAX_W-1]");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] shadow;
    logic [DATA_WIDTH-1:0] active;
    logic                  ovf_evt;

    assign weight_o = shadow;

    // Swap samples the pre-edge shadow, so swap+shift moves both registers in one edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow  <= '0;
            active  <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            swap_o  <= 1'b0;
        end else begin
            if (wshift_i) shadow <= weight_i;
            if (swap_i)   active <= shadow;
            data_o  <= data_i;
            valid_o <= valid_i;
            swap_o  <= swap_i;
        end
    end

    mac_ws_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .MUL_PIPE   (MUL_PIPE),
        .SAT_EN     (SAT_EN)
    ) u_mac (
        .clk         (clk),
        .rstn        (rstn),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .weight_i    (active),
        .acc_i       (acc_i),
        .acc_o       (acc_o),
        .acc_valid_o (acc_valid_o),
        .ovf_evt_o   (ovf_evt)
    );

    // A fresh overflow beats a clear landing on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          ovf_o <= 1'b0;
        else if (ovf_evt)   ovf_o <= 1'b1;
        else if (ovf_clr_i) ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed bench: four PEs (MUL_PIPE 0/1 x SAT_EN 1/0) share stimulus and are
// checked against hand-computed results at their own latency.
module tb_pe_ws_dbuf;

    logic        clk, rstn, valid_i, wshift_i, swap_i;
    logic [15:0] data_i, weight_i;
    logic [39:0] acc_i;
    logic [1:0]  ovf_clr;

    logic [15:0] data_o [4];
    logic [15:0] weight_o [4];
    logic [39:0] acc_o [4];
    logic        valid_o [4];
    logic        swap_o [4];
    logic        acc_valid_o [4];
    logic        ovf_o [4];

    int checks = 0;
    int failures = 0;

    // Instance g: MUL_PIPE = g%2, SAT_EN = (g<2).
    for (genvar g = 0; g < 4; g++) begin : g_dut
        pe_ws_dbuf #(
            .DATA_WIDTH (16),
            .ACC_WIDTH  (40),
            .MUL_PIPE   (g % 2),
            .SAT_EN     ((g < 2) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .valid_i     (valid_i),
            .data_i      (data_i),
            .acc_i       (acc_i),
            .data_o      (data_o[g]),
            .valid_o     (valid_o[g]),
            .acc_o       (acc_o[g]),
            .acc_valid_o (acc_valid_o[g]),
            .wshift_i    (wshift_i),
            .weight_i    (weight_i),
            .weight_o    (weight_o[g]),
            .swap_i      (swap_i),
            .swap_o      (swap_o[g]),
            .ovf_o       (ovf_o[g]),
            .ovf_clr_i   (ovf_clr[g%2])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [15:0] d, input logic [39:0] a,
                       input logic sh, input logic [15:0] w, input logic sw);
        valid_i = v; data_i = d; acc_i = a; wshift_i = sh; weight_i = w; swap_i = sw;
    endtask

    task automatic chk_acc(input string tag, input int p, input logic [39:0] e, input logic ev);
        for (int g = 0; g < 4; g++) begin
            if ((g % 2) == p) begin
                chk($sformatf("%s_acc_u%0d", tag, g), 64'(acc_o[g]), 64'(e));
                chk($sformatf("%s_accv_u%0d", tag, g), 64'(acc_valid_o[g]), 64'(ev));
            end
        end
    endtask

    task automatic chk_sat(input string tag, input int p, input logic [39:0] es, input logic [39:0] ew);
        for (int g = 0; g < 4; g++) begin
            if ((g % 2) == p) begin
                chk($sformatf("%s_acc_u%0d", tag, g), 64'(acc_o[g]), 64'((g < 2) ? es : ew));
                chk($sformatf("%s_ovf_u%0d", tag, g), 64'(ovf_o[g]), 64'(1));
            end
        end
    endtask

    task automatic chk_ovf(input string tag, input logic e);
        for (int g = 0; g < 4; g++)
            chk($sformatf("%s_ovf_u%0d", tag, g), 64'(ovf_o[g]), 64'(e));
    endtask

    task automatic chk_pass(input string tag, input logic [15:0] d, input logic v,
                            input logic sw, input logic [15:0] w);
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s_data_u%0d", tag, g), 64'(data_o[g]), 64'(d));
            chk($sformatf("%s_valid_u%0d", tag, g), 64'(valid_o[g]), 64'(v));
            chk($sformatf("%s_swap_u%0d", tag, g), 64'(swap_o[g]), 64'(sw));
            chk($sformatf("%s_wo_u%0d", tag, g), 64'(weight_o[g]), 64'(w));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_pass(tag, 16'd0, 1'b0, 1'b0, 16'd0);
        chk_acc(tag, 0, 40'd0, 1'b0);
        chk_acc(tag, 1, 40'd0, 1'b0);
        chk_ovf(tag, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        ovf_clr = 2'b00;
        drv(0, 0, 0, 0, 0, 0);
        #12;
        chk_zero("rst");
        rstn = 1'b1;

        // 1: load weight 5, swap, then 3*5+10
        drv(0, 0, 0, 1, 16'd5, 0); step();
        chk_pass("t1_shift", 16'd0, 0, 0, 16'd5);
        drv(0, 0, 0, 0, 0, 1); step();
        chk_pass("t1_swap", 16'd0, 0, 1, 16'd5);
        drv(1, 16'd3, 40'd10, 0, 0, 0); step();
        chk_pass("t1_d", 16'd3, 1, 0, 16'd5);
        chk_acc("t1_e1", 0, 40'd25, 1);
        chk_acc("t1_e1", 1, 40'd0, 0);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_acc("t1_e2", 0, 40'd25, 0);
        chk_acc("t1_e2", 1, 40'd25, 1);
        step();
        chk_acc("t1_e3", 1, 40'd25, 0);

        // 2: active=2, shadow=7; swap-cycle data uses old weight
        drv(0, 0, 0, 1, 16'd2, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();
        drv(0, 0, 0, 1, 16'd7, 0); step();
        drv(1, 16'd1, 40'd100, 0, 0, 1); step();
        chk_pass("t2_a", 16'd1, 1, 1, 16'd7);
        chk_acc("t2_a", 0, 40'd102, 1);
        drv(1, 16'd1, 40'd100, 0, 0, 0); step();
        chk_pass("t2_b", 16'd1, 1, 0, 16'd7);
        chk_acc("t2_b", 0, 40'd107, 1);
        chk_acc("t2_b", 1, 40'd102, 1);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_acc("t2_c", 0, 40'd107, 0);
        chk_acc("t2_c", 1, 40'd107, 1);

        // 3: shadow=4 then shift 9 + swap together
        drv(0, 0, 0, 1, 16'd4, 0); step();
        drv(0, 0, 0, 1, 16'd9, 1); step();
        chk_pass("t3", 16'd0, 0, 1, 16'd9);
        drv(1, 16'd1, 40'd0, 0, 0, 0); step();
        chk_acc("t3_a", 0, 40'd4, 1);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_acc("t3_b", 1, 40'd4, 1);

        // 4: saturation with w=1; 2^39-10+100 overflows positive
        drv(0, 0, 0, 1, 16'd1, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();
        drv(1, 16'd100, 40'h7F_FFFF_FFF6, 0, 0, 0); step();
        chk_sat("t4p_e1", 0, 40'h7F_FFFF_FFFF, 40'h80_0000_005A);
        chk("t4p_e1_ovf_u1", 64'(ovf_o[1]), 64'(0));
        drv(0, 0, 0, 0, 0, 0); step();
        chk_sat("t4p_e2", 1, 40'h7F_FFFF_FFFF, 40'h80_0000_005A);
        ovf_clr = 2'b11; step();
        chk_ovf("t4_clr", 1'b0);
        drv(1, 16'd100, 40'h7F_FFFF_FFF6, 0, 0, 0); ovf_clr = 2'b01; step();
        chk("t4_set_clr_u0", 64'(ovf_o[0]), 64'(1));
        chk("t4_set_clr_u2", 64'(ovf_o[2]), 64'(1));
        drv(0, 0, 0, 0, 0, 0); ovf_clr = 2'b10; step();
        ovf_clr = 2'b00;
        chk_ovf("t4_set_clr", 1'b1);
        // -2^39+10 - 100 overflows negative
        drv(1, 16'hFF9C, 40'h80_0000_000A, 0, 0, 0); step();
        chk_sat("t4n_e1", 0, 40'h80_0000_0000, 40'h7F_FFFF_FFA6);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_sat("t4n_e2", 1, 40'h80_0000_0000, 40'h7F_FFFF_FFA6);

        // 5: bubbles 1,0,1 with w=1
        drv(1, 16'd5, 40'd1, 0, 0, 0); step();
        chk_pass("t5_b1", 16'd5, 1, 0, 16'd1);
        chk_acc("t5_b1", 0, 40'd6, 1);
        drv(0, 16'd7, 40'd999, 0, 0, 0); step();
        chk_pass("t5_b2", 16'd7, 0, 0, 16'd1);
        chk_acc("t5_b2", 0, 40'd6, 0);
        chk_acc("t5_b2", 1, 40'd6, 1);
        drv(1, 16'd2, 40'd3, 0, 0, 0); step();
        chk_pass("t5_b3", 16'd2, 1, 0, 16'd1);
        chk_acc("t5_b3", 0, 40'd5, 1);
        chk_acc("t5_b3", 1, 40'd6, 0);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_acc("t5_b4", 1, 40'd5, 1);

        // 6: async reset between edges mid-stream, then swap with no prior shift
        drv(1, 16'd5, 40'd1, 0, 0, 0); step();
        #2 rstn = 1'b0;
        #1 chk_zero("t6_rst");
        #2 rstn = 1'b1;
        drv(0, 0, 0, 0, 0, 1); step();
        drv(1, 16'd5, 40'd77, 0, 0, 0); step();
        chk_acc("t6_a", 0, 40'd77, 1);
        drv(0, 0, 0, 0, 0, 0); step();
        chk_acc("t6_b", 1, 40'd77, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
